btn_press_decoder: RTL

Input-side counterpart to the counter/display output path. Converts the raw, bouncing push-button into a debounced level, one-cycle short-press and long-press strobes, and a 3-bit user value. A short tap increments the value; a long hold decrements it. The 3-bit value drives the LED bank and the segment decoder in place of the free-running counter.

---
 rtl/btn_press_decoder_pkg.sv | 15 +
 rtl/btn_press_decoder_if.sv | 11 +
 rtl/btn_press_decoder_sync.sv | 22 ++
 rtl/btn_press_decoder.sv | 110 +++++++++++
 4 files changed

// File: rtl/btn_press_decoder_pkg.sv
// Shared types and defaults for the push-button front end.
package btn_pkg;

   typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_REL} state_t;
   typedef enum logic {SHORT, LONG} kind_t;

   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_LONG_CYCLES     = 50_000_000;

   // A short tap counts the user value up, a long hold counts it down; both wrap mod 8.
   function automatic logic [2:0] step_value(input logic [2:0] v, input kind_t k);
      return (k == SHORT) ? v + 3'd1 : v - 3'd1;
   endfunction

endpackage

// File: rtl/btn_press_decoder_if.sv
// Button input plus decoded level, strobes and user value.
interface btn_press_decoder_if;
   logic       btn;
   logic       pressed;
   logic       short_pulse;
   logic       long_pulse;
   logic [2:0] value;

   modport master (input btn, output pressed, short_pulse, long_pulse, value);
   modport slave  (output btn, input pressed, short_pulse, long_pulse, value);
endinterface

// File: rtl/btn_press_decoder_sync.sv
// Two-flop synchronizer for asynchronous button inputs.
module btn_sync (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic sync_p0;
   logic sync_p1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= d;
         sync_p1 <= sync_p0;
      end
   end

   assign q = sync_p1;
endmodule

// File: rtl/btn_press_decoder.sv
// Debounces the button and classifies each press as short or long,
// stepping a 3-bit user value up on short taps and down on long holds.
module btn_press_decoder
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input logic                 clk,
   input logic                 reset,
   btn_press_decoder_if.master bus
);
   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_CYCLES);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   logic              btn_s;
   state_t            state;
   kind_t             kind;
   logic [DEB_W-1:0]  deb_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              pressed_r;
   logic              short_r;
   logic              long_r;
   logic [2:0]        value_r;

   btn_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.btn),
      .q     (btn_s)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         kind      <= SHORT;
         deb_cnt   <= '0;
         hold_cnt  <= '0;
         pressed_r <= 1'b0;
         short_r   <= 1'b0;
         long_r    <= 1'b0;
         value_r   <= 3'b000;
      end else begin
         short_r <= 1'b0;
         long_r  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (btn_s) begin
                  state   <= DEB_PRESS;
                  deb_cnt <= '0;
               end
            end
            DEB_PRESS: begin
               if (!btn_s) begin
                  state <= IDLE;
               end else if (deb_cnt == DEB_LAST) begin
                  state     <= HELD;
                  pressed_r <= 1'b1;
                  hold_cnt  <= '0;
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end
            HELD: begin
               if (!btn_s) begin
                  state   <= DEB_REL;
                  deb_cnt <= '0;
                  kind    <= SHORT;
               end else if (hold_cnt == HOLD_LAST) begin
                  state   <= LONG_HELD;
                  long_r  <= 1'b1;
                  value_r <= step_value(value_r, LONG);
               end else begin
                  hold_cnt <= hold_cnt + HOLD_W'(1);
               end
            end
            LONG_HELD: begin
               if (!btn_s) begin
                  state   <= DEB_REL;
                  deb_cnt <= '0;
                  kind    <= LONG;
               end
            end
            DEB_REL: begin
               // A bounce resumes the held state with hold_cnt frozen, so no second long strobe.
               if (btn_s) begin
                  state <= (kind == SHORT) ? HELD : LONG_HELD;
               end else if (deb_cnt == DEB_LAST) begin
                  state     <= IDLE;
                  pressed_r <= 1'b0;
                  if (kind == SHORT) begin
                     short_r <= 1'b1;
                     value_r <= step_value(value_r, SHORT);
                  end
               end else begin
                  deb_cnt <= deb_cnt + DEB_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.pressed     = pressed_r;
   assign bus.short_pulse = short_r;
   assign bus.long_pulse  = long_r;
   assign bus.value       = value_r;
endmodule
